// File: rtl/adc_frame_pkg.sv
// Shared constants, FSM state type and header byte helper for the ADC frame packer.
package adc_frame_pkg;

  localparam logic [7:0] MAGIC0 = 8'hA5;
  localparam logic [7:0] MAGIC1 = 8'h5A;
  localparam int unsigned HDR_LEN = 10;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPayHi,
    StPayLo
  } state_e;

  localparam logic [3:0] HdrMagic0 = 4'd0;
  localparam logic [3:0] HdrMagic1 = 4'd1;
  localparam logic [3:0] HdrSeqHi  = 4'd2;
  localparam logic [3:0] HdrSeqLo  = 4'd3;
  localparam logic [3:0] HdrNHi    = 4'd4;
  localparam logic [3:0] HdrNLo    = 4'd5;
  localparam logic [3:0] HdrMHi    = 4'd6;
  localparam logic [3:0] HdrMLo    = 4'd7;
  localparam logic [3:0] HdrCntHi  = 4'd8;
  localparam logic [3:0] HdrCntLo  = 4'd9;

  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [15:0] seq,
                                          input logic [15:0] n,
                                          input logic [15:0] m,
                                          input logic [15:0] cnt);
    logic [7:0] b;
    case (idx)
      HdrMagic0: b = MAGIC0;
      HdrMagic1: b = MAGIC1;
      HdrSeqHi:  b = seq[15:8];
      HdrSeqLo:  b = seq[7:0];
      HdrNHi:    b = n[15:8];
      HdrNLo:    b = n[7:0];
      HdrMHi:    b = m[15:8];
      HdrMLo:    b = m[7:0];
      HdrCntHi:  b = cnt[15:8];
      default:   b = cnt[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Sample buffer with first-word-fall-through read data and wrap-flag pointers.
module adc_sample_fifo #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic [Width-1:0] rd_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [AddrW-1:0] rd_addr_nxt;
  logic             wr_fire, rd_fire;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // full/empty come from registered pointers: a same-cycle read never frees a slot for the write.
  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
  end

  assign rd_addr_nxt = rd_ptr_q[AddrW-1:0] + AddrW'(1);
  assign rd_data_o   = mem_q[rd_ptr_q[AddrW-1:0]];
  // Entry behind the head, so the next high byte can be registered on the pop cycle.
  assign rd_next_o   = mem_q[rd_addr_nxt];

endmodule

// File: rtl/adc_frame_packer.sv
// Buffers ADC samples and emits framed byte records (header + big-endian payload) on AXI-Stream.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int unsigned SamplesPerFrame = 64,
  parameter int unsigned FifoDepth       = 256,
  parameter int unsigned TimeoutCycles   = 125000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        adc_valid_i,
  input  logic [15:0] adc_data_i,
  input  logic [15:0] n_i,
  input  logic [15:0] m_i,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic        m_axis_tlast_o,
  output logic [15:0] frame_count_o,
  output logic [15:0] drop_count_o
);

  localparam int unsigned LvlW = $clog2(FifoDepth) + 1;
  localparam logic [LvlW-1:0] SpfLvl = LvlW'(SamplesPerFrame);

  logic            fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [LvlW-1:0] fifo_level;
  logic [15:0]     head, head_nxt;
  logic            trigger, drop;

  state_e      state_q;
  logic [3:0]  hdr_idx_q;
  logic [15:0] seq_q, n_q, m_q, cnt_q, sent_q, frame_count_q, drop_count_q;
  logic [31:0] tmo_q;
  logic [7:0]  tdata_q;
  logic        tvalid_q, tlast_q;

  assign fifo_wr = adc_valid_i && enable_i && !fifo_full;
  assign drop    = adc_valid_i && enable_i && fifo_full;
  assign fifo_rd = tvalid_q && m_axis_tready_i && (state_q == StPayLo);
  assign trigger = (state_q == StIdle) &&
                   ((fifo_level >= SpfLvl) || (!fifo_empty && (tmo_q >= TimeoutCycles)));

  adc_sample_fifo #(
    .Depth (FifoDepth),
    .Width (16)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (fifo_wr),
    .wr_data_i (adc_data_i),
    .rd_en_i   (fifo_rd),
    .rd_data_o (head),
    .rd_next_o (head_nxt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if ((state_q != StIdle) || fifo_empty || trigger) begin
      tmo_q <= '0;
    end else if (tmo_q < TimeoutCycles) begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      hdr_idx_q     <= '0;
      seq_q         <= '0;
      n_q           <= '0;
      m_q           <= '0;
      cnt_q         <= '0;
      sent_q        <= '0;
      frame_count_q <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q   <= StHdr;
            hdr_idx_q <= '0;
            sent_q    <= '0;
            cnt_q     <= (fifo_level >= SpfLvl) ? 16'(SpfLvl) : 16'(fifo_level);
            n_q       <= n_i;
            m_q       <= m_i;
            tdata_q   <= MAGIC0;
            tvalid_q  <= 1'b1;
            tlast_q   <= 1'b0;
          end
        end
        StHdr: begin
          if (m_axis_tready_i) begin
            if (hdr_idx_q == 4'(HDR_LEN - 1)) begin
              state_q <= StPayHi;
              tdata_q <= head[15:8];
            end else begin
              hdr_idx_q <= hdr_idx_q + 4'd1;
              tdata_q   <= hdr_byte(hdr_idx_q + 4'd1, seq_q, n_q, m_q, cnt_q);
            end
          end
        end
        StPayHi: begin
          if (m_axis_tready_i) begin
            state_q <= StPayLo;
            tdata_q <= head[7:0];
            tlast_q <= (sent_q == cnt_q - 16'd1);
          end
        end
        StPayLo: begin
          if (m_axis_tready_i) begin
            if (tlast_q) begin
              state_q       <= StIdle;
              tdata_q       <= '0;
              tvalid_q      <= 1'b0;
              tlast_q       <= 1'b0;
              seq_q         <= seq_q + 16'd1;
              frame_count_q <= frame_count_q + 16'd1;
            end else begin
              // Head is popped on this edge, so the following sample sits one slot behind it.
              state_q <= StPayHi;
              sent_q  <= sent_q + 16'd1;
              tdata_q <= head_nxt[15:8];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign frame_count_o   = frame_count_q;
  assign drop_count_o    = drop_count_q;

endmodule
